// File: rtl/hazard_flush_ctrl_if.sv
// Pipeline-side bundle for hazard_flush_ctrl: ID/EX operand info, memory
// handshake and the stage-register control lines it returns.
// master = pipeline datapath, slave = the hazard/flush controller.
`timescale 1ns/1ps
interface hazard_flush_ctrl_if;
    logic [4:0]  ID_rs1;
    logic [4:0]  ID_rs2;
    logic        ID_use_rs1;
    logic        ID_use_rs2;
    logic [4:0]  EX_rd;
    logic        EX_mem_read;
    logic        EX_branch_taken;
    logic        MEM_req;
    logic        MEM_ready;
    logic        PC_stall;
    logic        IF_ID_stall;
    logic        IF_Flush;
    logic        ID_Flush_branch;
    logic        ID_Flush_hazard;
    logic        ID_EX_hold;
    logic        EX_MEM_hold;
    logic        MEM_WB_flush;
    logic        mem_timeout;
    logic [31:0] perf_lu_cnt;
    logic [31:0] perf_br_cnt;

    modport master (
        output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, EX_rd, EX_mem_read,
               EX_branch_taken, MEM_req, MEM_ready,
        input  PC_stall, IF_ID_stall, IF_Flush, ID_Flush_branch, ID_Flush_hazard,
               ID_EX_hold, EX_MEM_hold, MEM_WB_flush, mem_timeout,
               perf_lu_cnt, perf_br_cnt
    );

    modport slave (
        input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, EX_rd, EX_mem_read,
               EX_branch_taken, MEM_req, MEM_ready,
        output PC_stall, IF_ID_stall, IF_Flush, ID_Flush_branch, ID_Flush_hazard,
               ID_EX_hold, EX_MEM_hold, MEM_WB_flush, mem_timeout,
               perf_lu_cnt, perf_br_cnt
    );
endinterface

// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard / flush controller: load-use bubbles, taken-branch squash,
// data-memory wait freeze and a memory watchdog (TIMEOUT is sticky until reset).
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined;
// otherwise perf_lu_cnt / perf_br_cnt are tied to zero.
`timescale 1ns/1ps
module hazard_flush_ctrl #(
    parameter int MEM_TIMEOUT = 64,  // 0 disables the watchdog
    parameter int TO_W        = 8    // 2**TO_W must exceed MEM_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    hazard_flush_ctrl_if.slave hz
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, TIMEOUT} state_t;

    state_t          state_q, state_d;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            mem_timeout_q, mem_timeout_d;
    logic            freeze;
    logic            lu;

    // Freeze covers both a stalled access and the dead TIMEOUT state.
    assign freeze = (state_q == TIMEOUT) | (hz.MEM_req & ~hz.MEM_ready);

    // Load-use: EX holds a load whose (non-x0) destination the ID instruction reads.
    assign lu = hz.EX_mem_read & (hz.EX_rd != 5'd0) &
                ((hz.ID_use_rs1 & (hz.ID_rs1 == hz.EX_rd)) |
                 (hz.ID_use_rs2 & (hz.ID_rs2 == hz.EX_rd)));

    // State, wait counter and sticky timeout flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Next state: enter MEM_WAIT on a stalled access, leave on ready or withdrawal,
    // trip the watchdog once MEM_TIMEOUT wait cycles have already elapsed.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (hz.MEM_req & ~hz.MEM_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = TO_W'(1);
                end
            end
            MEM_WAIT: begin
                if (hz.MEM_ready | ~hz.MEM_req) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if ((MEM_TIMEOUT != 0) && (wait_cnt_q == TO_W'(MEM_TIMEOUT))) begin
                    state_d = TIMEOUT;
                end else if (wait_cnt_q != {TO_W{1'b1}}) begin
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
                end
            end
            TIMEOUT: begin
                state_d = TIMEOUT;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
        mem_timeout_d = mem_timeout_q | (state_d == TIMEOUT);
    end

    // Control outputs: freeze > branch > load-use, all forced low while in reset.
    always_comb begin
        hz.PC_stall        = 1'b0;
        hz.IF_ID_stall     = 1'b0;
        hz.IF_Flush        = 1'b0;
        hz.ID_Flush_branch = 1'b0;
        hz.ID_Flush_hazard = 1'b0;
        hz.ID_EX_hold      = 1'b0;
        hz.EX_MEM_hold     = 1'b0;
        hz.MEM_WB_flush    = 1'b0;
        hz.mem_timeout     = mem_timeout_q & ~reset;
        if (!reset) begin
            if (freeze) begin
                hz.PC_stall     = 1'b1;
                hz.IF_ID_stall  = 1'b1;
                hz.ID_EX_hold   = 1'b1;
                hz.EX_MEM_hold  = 1'b1;
                hz.MEM_WB_flush = 1'b1;
            end else if (hz.EX_branch_taken) begin
                hz.IF_Flush        = 1'b1;
                hz.ID_Flush_branch = 1'b1;
            end else if (lu) begin
                hz.PC_stall        = 1'b1;
                hz.IF_ID_stall     = 1'b1;
                hz.ID_Flush_hazard = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_lu_q, perf_lu_d;
    logic [31:0] perf_br_q, perf_br_d;
    logic        lu_active;
    logic        br_active;

    assign lu_active = ~freeze & ~hz.EX_branch_taken & lu;
    assign br_active = ~freeze & hz.EX_branch_taken;

    // Wrapping event counters for load-use bubbles and branch squashes.
    always_comb begin
        perf_lu_d = perf_lu_q + (lu_active ? 32'd1 : 32'd0);
        perf_br_d = perf_br_q + (br_active ? 32'd1 : 32'd0);
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_lu_q <= '0;
            perf_br_q <= '0;
        end else begin
            perf_lu_q <= perf_lu_d;
            perf_br_q <= perf_br_d;
        end
    end

    assign hz.perf_lu_cnt = perf_lu_q;
    assign hz.perf_br_cnt = perf_br_q;
`else
    assign hz.perf_lu_cnt = 32'd0;
    assign hz.perf_br_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Bench for hazard_flush_ctrl: a vector table of single-cycle hazard cases plus
// hand-written memory-wait, watchdog and async-reset sequences. dut_a uses a
// 4-cycle watchdog, dut_b has the watchdog disabled.
`timescale 1ns/1ps
module tb_hazard_flush_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [4:0] s_rs1, s_rs2, s_rd;
    logic       s_use1, s_use2, s_mr, s_br, s_req, s_rdy;

    hazard_flush_ctrl_if ifa();
    hazard_flush_ctrl_if ifb();

    assign ifa.ID_rs1 = s_rs1;       assign ifb.ID_rs1 = s_rs1;
    assign ifa.ID_rs2 = s_rs2;       assign ifb.ID_rs2 = s_rs2;
    assign ifa.ID_use_rs1 = s_use1;  assign ifb.ID_use_rs1 = s_use1;
    assign ifa.ID_use_rs2 = s_use2;  assign ifb.ID_use_rs2 = s_use2;
    assign ifa.EX_rd = s_rd;         assign ifb.EX_rd = s_rd;
    assign ifa.EX_mem_read = s_mr;   assign ifb.EX_mem_read = s_mr;
    assign ifa.EX_branch_taken = s_br; assign ifb.EX_branch_taken = s_br;
    assign ifa.MEM_req = s_req;      assign ifb.MEM_req = s_req;
    assign ifa.MEM_ready = s_rdy;    assign ifb.MEM_ready = s_rdy;

    hazard_flush_ctrl #(.MEM_TIMEOUT(4), .TO_W(8)) dut_a (.clk(clk), .reset(reset), .hz(ifa.slave));
    hazard_flush_ctrl #(.MEM_TIMEOUT(0), .TO_W(8)) dut_b (.clk(clk), .reset(reset), .hz(ifb.slave));

    // {PC_stall, IF_ID_stall, IF_Flush, ID_Flush_branch, ID_Flush_hazard,
    //  ID_EX_hold, EX_MEM_hold, MEM_WB_flush, mem_timeout}
    logic [8:0] out_a, out_b;
    assign out_a = {ifa.PC_stall, ifa.IF_ID_stall, ifa.IF_Flush, ifa.ID_Flush_branch,
                    ifa.ID_Flush_hazard, ifa.ID_EX_hold, ifa.EX_MEM_hold,
                    ifa.MEM_WB_flush, ifa.mem_timeout};
    assign out_b = {ifb.PC_stall, ifb.IF_ID_stall, ifb.IF_Flush, ifb.ID_Flush_branch,
                    ifb.ID_Flush_hazard, ifb.ID_EX_hold, ifb.EX_MEM_hold,
                    ifb.MEM_WB_flush, ifb.mem_timeout};

    localparam logic [8:0] O_NONE = 9'b000000000;
    localparam logic [8:0] O_LU   = 9'b110010000;
    localparam logic [8:0] O_BR   = 9'b001100000;
    localparam logic [8:0] O_FRZ  = 9'b110001110;
    localparam logic [8:0] O_TO   = 9'b110001111;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       use1, use2, mr, br, req, rdy;
        logic [8:0] exp;
    } vec_t;

    vec_t       vecs [13];
    logic [8:0] exp_q [$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [31:0] exp_lu = 32'd0;
    logic [31:0] exp_br = 32'd0;

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic use1, input logic use2, input logic [4:0] rd,
                                input logic mr, input logic br, input logic req,
                                input logic rdy, input logic [8:0] exp);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.use1 = use1; v.use2 = use2; v.rd = rd;
        v.mr = mr; v.br = br; v.req = req; v.rdy = rdy; v.exp = exp;
        return v;
    endfunction

    function automatic logic [31:0] perf_exp(input logic [31:0] model);
`ifdef HAZARD_PERF_CNT_EN
        return model;
`else
        return (model & 32'd0);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        s_rs1 = v.rs1; s_rs2 = v.rs2; s_use1 = v.use1; s_use2 = v.use2;
        s_rd = v.rd; s_mr = v.mr; s_br = v.br; s_req = v.req; s_rdy = v.rdy;
    endtask

    // One transaction: drive just after a rising edge, compare mid-cycle,
    // then advance the perf model across the next edge.
    task automatic apply(input string name, input vec_t v, input bit on_b);
        logic [8:0] e;
        drive(v);
        exp_q.push_back(v.exp);
        @(negedge clk);
        e = exp_q.pop_front();
        check(name, 32'(on_b ? out_b : out_a), 32'(e));
        if (!on_b) begin
            check({name, ".perf_lu"}, ifa.perf_lu_cnt, perf_exp(exp_lu));
            check({name, ".perf_br"}, ifa.perf_br_cnt, perf_exp(exp_br));
        end
        $display("%-10s dut=%s rs1=%0d rs2=%0d u=%b%b rd=%0d ld=%b br=%b req=%b rdy=%b out=%b exp=%b",
                 name, on_b ? "b" : "a", v.rs1, v.rs2, v.use1, v.use2, v.rd, v.mr, v.br,
                 v.req, v.rdy, on_b ? out_b : out_a, e);
        @(posedge clk);
        if (!on_b) begin
            if (e[4]) exp_lu = exp_lu + 32'd1;
            if (e[5]) exp_br = exp_br + 32'd1;
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "bench time limit");
    end

    initial begin
        vec_t idle, lub;
        idle = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
        lub  = mk(5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, O_BR);

        //            rs1    rs2    u1    u2    rd     ld    br    req   rdy   expected
        vecs[0]  = mk(5'd5,  5'd9,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, O_LU);
        vecs[1]  = mk(5'd0,  5'd9,  1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, O_NONE);
        vecs[2]  = mk(5'd5,  5'd9,  1'b1, 1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, O_BR);
        vecs[3]  = mk(5'd1,  5'd12, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, O_LU);
        vecs[4]  = mk(5'd1,  5'd12, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE);
        vecs[5]  = mk(5'd5,  5'd9,  1'b1, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
        vecs[6]  = mk(5'd5,  5'd9,  1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, O_NONE);
        vecs[7]  = mk(5'd5,  5'd9,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 1'b1, 1'b1, O_LU);
        vecs[8]  = mk(5'd5,  5'd9,  1'b1, 1'b0, 5'd5,  1'b1, 1'b1, 1'b1, 1'b0, O_FRZ);
        vecs[9]  = mk(5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
        vecs[10] = mk(5'd0,  5'd0,  1'b0, 1'b0, 5'd3,  1'b0, 1'b1, 1'b0, 1'b0, O_BR);
        vecs[11] = mk(5'd3,  5'd3,  1'b1, 1'b1, 5'd4,  1'b1, 1'b0, 1'b0, 1'b0, O_NONE);
        vecs[12] = mk(5'd31, 5'd30, 1'b1, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, O_LU);

        // Reset state: hazard inputs active, outputs must still read zero.
        reset = 1'b1;
        drive(vecs[0]);
        @(negedge clk);
        check("rst.out_a", 32'(out_a), 32'(O_NONE));
        check("rst.out_b", 32'(out_b), 32'(O_NONE));
        check("rst.perf_lu", ifa.perf_lu_cnt, 32'd0);
        check("rst.perf_br", ifa.perf_br_cnt, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 13; i++) apply($sformatf("vec%0d", i), vecs[i], 1'b0);

        // Memory wait with a taken branch held in EX, then release.
        for (int i = 0; i < 3; i++)
            apply($sformatf("mw%0d", i), mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, O_FRZ), 1'b0);
        apply("mw_rdy", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, O_BR), 1'b0);
        apply("mw_post", idle, 1'b0);

        // Long wait on the watchdog-less instance: never trips, counter saturates.
        for (int i = 0; i < 300; i++)
            apply($sformatf("long%0d", i), mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_FRZ), 1'b1);
        check("long.wait_cnt_sat", 32'(dut_b.wait_cnt_q), 32'd255);
        apply("long_rdy", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_NONE), 1'b1);
        check("long.wait_cnt_clr", 32'(dut_b.wait_cnt_q), 32'd0);
        apply("long_post", idle, 1'b1);

        // dut_a has timed out during the long wait; clear it.
        reset = 1'b1;
        exp_lu = 32'd0;
        exp_br = 32'd0;
        @(posedge clk);
        #1 reset = 1'b0;

        // Watchdog (4): wait counts 1..4 are tolerated, the next still-waiting edge trips it.
        for (int i = 0; i < 5; i++)
            apply($sformatf("to_w%0d", i), mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_FRZ), 1'b0);
        apply("to_hit", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_TO), 1'b0);
        apply("to_drop", mk(5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, O_TO), 1'b0);
        apply("to_idle", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_TO), 1'b0);

        // Async reset mid-cycle: everything clears before any clock edge.
        drive(lub);
        #2 reset = 1'b1;
        exp_lu = 32'd0;
        exp_br = 32'd0;
        #1;
        check("arst.out_a", 32'(out_a), 32'(O_NONE));
        check("arst.perf_lu", ifa.perf_lu_cnt, 32'd0);
        check("arst.perf_br", ifa.perf_br_cnt, 32'd0);
        $display("arst       dut=a out=%b exp=%b", out_a, O_NONE);
        @(posedge clk);
        #1 reset = 1'b0;
        apply("post_br", lub, 1'b0);
        apply("post_lu", mk(5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, O_LU), 1'b0);
        apply("post_idle", idle, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
